// File: rtl/logic_unit_checker_if.sv
// Purpose : bundles the checker's control, result and DUT-facing gate signals into one port.
// Latency : none; this file contains wires only.
// Backpressure: none; start is a level input, and results hold until the next start.
// Modports:
//   master - checker side: drives a/b and the results, and receives start, z_and and z_or.
//   slave  - environment side: drives start and the gate outputs, and observes the rest.
interface logic_unit_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             z_and;
    logic             z_or;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       fail_mask;

    modport master (
        input  start, z_and, z_or,
        output a, b, busy, done, pass, err_cnt, fail_mask
    );

    modport slave (
        output start, z_and, z_or,
        input  a, b, busy, done, pass, err_cnt, fail_mask
    );
endinterface

// File: rtl/logic_unit_checker.sv
// Purpose : self-test sequencer for the AND/OR gate block. It drives the patterns 00,01,10,11 and checks z_and/z_or.
// Latency : each pattern is held for STEP_CYCLES cycles, so a pass takes 4*STEP_CYCLES cycles; done rises on the last sample edge.
// Backpressure: start is ignored while busy. Results hold in DONE until the next start.
// Ports: clk, reset_n (async, active-low); bus (logic_unit_checker_if.master):
//   start in, z_and/z_or in, a/b out (registered), busy/done/pass out,
//   err_cnt out (saturating), fail_mask out (bit {a,b} set on any mismatch).
// Optional feature: define LOGIC_UNIT_CHECKER_LOOP_EN to keep looping passes while start
//   is high at the final sample edge. Errors accumulate across the looped passes.
module logic_unit_checker #(
    parameter int STEP_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    logic_unit_checker_if.master   bus
);
    localparam int               CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       mask_q;
    logic [ERR_W:0]   err_sum;
    logic [1:0]       mism;
    logic             launch, sample, last, wrap;

    // Control decode and saturating error update.
    always_comb begin
        launch = (state_q != DRIVE) && bus.start;
        sample = (state_q == DRIVE) && (cnt_q == LAST_CNT);
        last   = sample && (idx_q == 2'd3);
`ifdef LOGIC_UNIT_CHECKER_LOOP_EN
        wrap   = bus.start;
`else
        wrap   = 1'b0;
`endif
        mism    = {1'b0, bus.z_and != (idx_q[1] & idx_q[0])}
                + {1'b0, bus.z_or  != (idx_q[1] | idx_q[0])};
        // One extra bit catches overflow, so the counter clamps instead of wrapping.
        err_sum = {1'b0, err_q} + {{(ERR_W-1){1'b0}}, mism};
        err_d   = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = DRIVE;
            DRIVE:      if (last && !wrap) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath. idx wraps 3 -> 0 on the last sample, so a/b return to 00 in
    // DONE and also on a looped pass, with no separate clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            err_q  <= '0;
            mask_q <= '0;
        end else if (launch) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            err_q  <= '0;
            mask_q <= '0;
        end else if (state_q == DRIVE) begin
            if (sample) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
                err_q <= err_d;
                if (mism != 2'd0) mask_q[idx_q] <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Outputs. a/b come straight from the idx register, so they are glitch-free.
    always_comb begin
        bus.a         = idx_q[1];
        bus.b         = idx_q[0];
        bus.busy      = (state_q == DRIVE);
        bus.done      = (state_q == DONE);
        bus.pass      = (state_q == DONE) && (err_q == '0);
        bus.err_cnt   = err_q;
        bus.fail_mask = mask_q;
    end
endmodule

// File: tb/tb_logic_unit_checker.sv
// Purpose : directed self-checking bench for logic_unit_checker with a fault-injecting gate model.
// Latency : checks are made on the falling edge, half a cycle after each active edge.
// Backpressure: not applicable; start is driven as a level.
module tb_logic_unit_checker;
    logic clk;
    logic reset_n;
    int   mode;
    int   mode2;
    int   errors = 0;
    int   checks = 0;

    logic_unit_checker_if #(.ERR_W(8)) lu ();
    logic_unit_checker_if #(.ERR_W(2)) lu2 ();

    logic_unit_checker #(.STEP_CYCLES(4), .ERR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (lu.master)
    );

    logic_unit_checker #(.STEP_CYCLES(1), .ERR_W(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (lu2.master)
    );

    // Gate model: 0 ideal, 1 z_and stuck 0, 2 z_or stuck 1, 3 swapped, 4 both inverted.
    function automatic logic [1:0] resp(input int m, input logic a, input logic b);
        case (m)
            1:       return {1'b0, a | b};
            2:       return {a & b, 1'b1};
            3:       return {a | b, a & b};
            4:       return {~(a & b), ~(a | b)};
            default: return {a & b, a | b};
        endcase
    endfunction

    assign {lu.z_and, lu.z_or}   = resp(mode, lu.a, lu.b);
    assign {lu2.z_and, lu2.z_or} = resp(mode2, lu2.a, lu2.b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one start-pulse pass on the main instance and checks the pattern walk and the results.
    task automatic run_pass(input int m, input bit pulse6, input logic [7:0] e_err,
                            input logic [3:0] e_mask, input string tag);
        mode = m;
        @(negedge clk);
        lu.start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            lu.start = pulse6 && (k == 5);
            check($sformatf("%s ab k%0d", tag, k), {lu.a, lu.b}, k / 4);
            check($sformatf("%s busy k%0d", tag, k), lu.busy, 1);
        end
        @(negedge clk);
        check({tag, " done"}, lu.done, 1);
        check({tag, " busy_end"}, lu.busy, 0);
        check({tag, " ab_end"}, {lu.a, lu.b}, 0);
        check({tag, " err"}, lu.err_cnt, e_err);
        check({tag, " mask"}, lu.fail_mask, e_mask);
        check({tag, " pass"}, lu.pass, (e_err == 8'd0));
    endtask

    initial begin
        reset_n   = 1'b0;
        lu.start  = 1'b0;
        lu2.start = 1'b0;
        mode      = 0;
        mode2     = 4;
        #12;
        check("rst a", lu.a, 0);
        check("rst b", lu.b, 0);
        check("rst busy", lu.busy, 0);
        check("rst done", lu.done, 0);
        check("rst pass", lu.pass, 0);
        check("rst err", lu.err_cnt, 0);
        check("rst mask", lu.fail_mask, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", lu.busy, 0);

        // 1: ideal gate, then DONE holds while start stays low
        run_pass(0, 1'b0, 8'd0, 4'b0000, "ideal");
        repeat (3) @(negedge clk);
        check("hold done", lu.done, 1);
        check("hold pass", lu.pass, 1);

        // 2, 3: single-output faults, then swapped outputs
        run_pass(1, 1'b0, 8'd1, 4'b1000, "and_sa0");
        run_pass(2, 1'b0, 8'd1, 4'b0001, "or_sa1");
        run_pass(3, 1'b0, 8'd4, 4'b0110, "swap");

        // 4: a start pulse mid-pass has no effect
        run_pass(0, 1'b1, 8'd0, 4'b0000, "pulse6");

`ifndef LOGIC_UNIT_CHECKER_LOOP_EN
        // 4: start held high through the pass is ignored, and it restarts right after DONE
        mode = 1;
        @(negedge clk);
        lu.start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("held ab k%0d", k), {lu.a, lu.b}, k / 4);
        end
        @(negedge clk);
        check("held done", lu.done, 1);
        check("held err", lu.err_cnt, 1);
        @(negedge clk);
        check("restart busy", lu.busy, 1);
        check("restart done", lu.done, 0);
        check("restart err", lu.err_cnt, 0);
        check("restart mask", lu.fail_mask, 0);
        lu.start = 1'b0;
        repeat (16) @(negedge clk);
        check("restart done2", lu.done, 1);
        check("restart err2", lu.err_cnt, 1);
`else
        // 6: loop three passes with z_and stuck at 0
        mode = 1;
        @(negedge clk);
        lu.start = 1'b1;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k == 32) lu.start = 1'b0;
            check($sformatf("loop busy k%0d", k), lu.busy, 1);
            check($sformatf("loop ab k%0d", k), {lu.a, lu.b}, (k % 16) / 4);
        end
        @(negedge clk);
        check("loop done", lu.done, 1);
        check("loop err", lu.err_cnt, 3);
        check("loop mask", lu.fail_mask, 4'b1000);
        check("loop pass", lu.pass, 0);
`endif

        // 5: asynchronous reset in the middle of pattern 2
        mode = 2;
        @(negedge clk);
        lu.start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lu.start = 1'b0;
        end
        check("pre_rst ab", {lu.a, lu.b}, 2);
        check("pre_rst err", lu.err_cnt, 1);
        check("pre_rst mask", lu.fail_mask, 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        check("async ab", {lu.a, lu.b}, 0);
        check("async busy", lu.busy, 0);
        check("async err", lu.err_cnt, 0);
        check("async mask", lu.fail_mask, 0);
        check("async done", lu.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst busy", lu.busy, 0);
        check("post_rst done", lu.done, 0);
        check("post_rst ab", {lu.a, lu.b}, 0);

        // 3: STEP_CYCLES=1 with ERR_W=2 and both outputs inverted, so the error count saturates
        @(negedge clk);
        lu2.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lu2.start = 1'b0;
            check($sformatf("s1 busy k%0d", k), lu2.busy, 1);
            check($sformatf("s1 ab k%0d", k), {lu2.a, lu2.b}, k);
        end
        @(negedge clk);
        check("s1 done", lu2.done, 1);
        check("s1 busy_end", lu2.busy, 0);
        check("s1 err_sat", lu2.err_cnt, 3);
        check("s1 mask", lu2.fail_mask, 4'b1111);
        check("s1 pass", lu2.pass, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
